// File: rtl/ddr_cfg_apb_master.sv
// APB master issuing one configuration register access per sequencer request.
// Includes an ACCESS-phase timeout, sticky error flags and a completed-transfer counter.
module ddr_cfg_apb_master #(
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        I_sys_clk,
  input  logic        I_sys_rst_n,
  input  logic        I_req,
  input  logic [31:0] I_paddr,
  input  logic        I_pwrite,
  input  logic [31:0] I_pwdata,
  output logic        O_gnt,
  output logic [31:0] O_prdata,
  output logic        O_psel,
  output logic        O_penable,
  output logic        O_pwrite,
  output logic [31:0] O_paddr,
  output logic [31:0] O_pwdata,
  input  logic        I_pready,
  input  logic [31:0] I_prdata,
  input  logic        I_pslverr,
  input  logic        I_err_clr,
  output logic        O_busy,
  output logic        O_timeout,
  output logic        O_slverr,
  output logic [15:0] O_xfer_cnt
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic        gnt_q, gnt_d, busy_q, busy_d;
  logic        timeout_q, timeout_d, slverr_q, slverr_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d, prdata_q, prdata_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic        timeout_set, slverr_set;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    prdata_d    = prdata_q;
    timeout_set = 1'b0;
    slverr_set  = 1'b0;

    unique case (state_q)
      StIdle: begin
        wait_cnt_d = '0;
        if (I_req) begin
          state_d  = StSetup;
          paddr_d  = I_paddr;
          pwrite_d = I_pwrite;
          pwdata_d = I_pwdata;
        end
      end
      StSetup: begin
        state_d    = StAccess;
        wait_cnt_d = '0;
      end
      StAccess: begin
        if (I_pready) begin
          state_d    = StDone;
          slverr_set = I_pslverr;
          if (!pwrite_q) prdata_d = I_prdata;
        end else if (wait_cnt_q == TimeoutLast) begin
          state_d     = StDone;
          timeout_set = 1'b1;
          if (!pwrite_q) prdata_d = TIMEOUT_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so every output is a flop.
    psel_d    = (state_d == StSetup) || (state_d == StAccess);
    penable_d = (state_d == StAccess);
    gnt_d     = (state_d == StDone);
    busy_d    = (state_d != StIdle);

    // A set event in the same cycle as a clear leaves the flag set.
    timeout_d = timeout_set | (timeout_q & ~I_err_clr);
    slverr_d  = slverr_set | (slverr_q & ~I_err_clr);

    xfer_cnt_d = xfer_cnt_q;
    if ((state_q == StAccess) && (state_d == StDone) && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      gnt_q      <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      slverr_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      prdata_q   <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      slverr_q   <= slverr_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      prdata_q   <= prdata_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign O_gnt      = gnt_q;
  assign O_prdata   = prdata_q;
  assign O_psel     = psel_q;
  assign O_penable  = penable_q;
  assign O_pwrite   = pwrite_q;
  assign O_paddr    = paddr_q;
  assign O_pwdata   = pwdata_q;
  assign O_busy     = busy_q;
  assign O_timeout  = timeout_q;
  assign O_slverr   = slverr_q;
  assign O_xfer_cnt = xfer_cnt_q;

endmodule

// File: doc/ddr_cfg_apb_master.md
DDR_CFG_APB_MASTER -- requirements
Module: ddr_cfg_apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024: max ACCESS cycles waiting for pready before abort (legal range 2..65535).
REQ-002 SHALL have parameter TIMEOUT_DATA, default 32'hDEADBEEF: value returned on O_prdata for an aborted transfer.
REQ-003 I_sys_clk  in  1  clock; all logic rising-edge.
REQ-004 I_sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 I_req  in  1  request from config sequencer; held high with addr/write/wdata stable until O_gnt seen.
REQ-006 I_paddr  in  32  register address.
REQ-007 I_pwrite  in  1  1 = write, 0 = read.
REQ-008 I_pwdata  in  32  write data.
REQ-009 O_gnt  out  1  one-cycle completion pulse to sequencer.
REQ-010 O_prdata  out  32  read data, valid in O_gnt cycle, held until next completion.
REQ-011 O_psel, O_penable, O_pwrite  out  1 each  APB master controls.
REQ-012 O_paddr, O_pwdata  out  32 each  APB address / write data.
REQ-013 I_pready  in  1  APB slave ready.
REQ-014 I_prdata  in  32  APB read data.
REQ-015 I_pslverr  in  1  APB slave error.
REQ-016 I_err_clr  in  1  synchronous clear of sticky error flags.
REQ-017 O_busy  out  1  high in every state except IDLE.
REQ-018 O_timeout, O_slverr  out  1 each  sticky error flags.
REQ-019 O_xfer_cnt  out  16  completed-transfer count, saturating at 16'hFFFF.

Function
REQ-020 FSM states: IDLE, SETUP, ACCESS, DONE; all outputs registered.
REQ-021 IDLE: I_req=1 -> SETUP; I_paddr/I_pwrite/I_pwdata captured into O_paddr/O_pwrite/O_pwdata on the same edge.
REQ-022 SETUP: O_psel=1, O_penable=0, exactly one cycle, then ACCESS.
REQ-023 ACCESS: O_psel=1, O_penable=1; I_pready=1 -> DONE; APB address/data/direction held constant throughout.
REQ-024 ACCESS read completing with I_pready=1 -> I_prdata latched into O_prdata on that edge; write completion leaves O_prdata unchanged.
REQ-025 I_pslverr=1 with I_pready=1 -> O_slverr set to 1; transfer still completes normally; read data still latched.
REQ-026 ACCESS wait counter starts at 0 on entry; at count TIMEOUT_CYC-1 without I_pready -> DONE, O_timeout=1, O_prdata=TIMEOUT_DATA for reads.
REQ-027 DONE: O_psel=0, O_penable=0, O_gnt=1 for exactly one cycle, O_xfer_cnt increments unless saturated, next state IDLE.
REQ-028 IDLE in the cycle after DONE samples I_req; a requester deasserting req on the edge after gnt therefore never causes a duplicate transfer.
REQ-029 Request-to-gnt latency: 3 cycles minimum (IDLE sample, SETUP, ACCESS with pready=1, gnt asserted in DONE).
REQ-030 I_req changes while not in IDLE are ignored; no queueing, one outstanding transfer.
REQ-031 I_err_clr=1 clears O_timeout and O_slverr; a set event in the same cycle wins (flag stays 1).
REQ-032 O_psel and O_penable SHALL never both be 0→1 on the same edge; O_penable=1 implies O_psel=1.

Reset
REQ-033 Async reset -> IDLE; O_gnt, O_psel, O_penable, O_pwrite, O_busy, O_timeout, O_slverr = 0; O_paddr, O_pwdata, O_prdata = 0; O_xfer_cnt = 0; wait counter = 0.
REQ-034 Reset asserted mid-transfer SHALL drop O_psel/O_penable immediately (asynchronously) with no O_gnt issued; operation resumes from IDLE after release.

Verification
REQ-035 Write 32'h00000001 to 32'h41209000, pready tied 1 -> SETUP then ACCESS on O_paddr=41209000, O_pwrite=1, O_gnt 3 cycles after req, O_xfer_cnt=1.
REQ-036 Read 32'h4120924C, pready after 5 wait cycles with prdata=32'h80000100 -> O_gnt once, O_prdata=32'h80000100, APB signals stable across all wait cycles.
REQ-037 Read with pready never asserted, TIMEOUT_CYC=16 -> gnt after 16 ACCESS cycles, O_prdata=32'hDEADBEEF, O_timeout=1; I_err_clr pulse -> O_timeout=0.
REQ-038 Write completing with pslverr=1 -> O_slverr=1, O_gnt issued; simultaneous I_err_clr and pslverr -> O_slverr remains 1.
REQ-039 Back-to-back: req dropped one cycle after gnt then raised again -> exactly two APB transfers, no duplicate; req held high through gnt+1 -> verify IDLE sampling per REQ-028.
REQ-040 Reset asserted during ACCESS -> O_psel=0 same cycle, no O_gnt, O_xfer_cnt=0; next request after release completes normally.
